// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the mem_0 arbiter slice.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 33;
  localparam int DEF_DATA_W  = 512;
  localparam int DEF_BURST_W = 4;

  // Tag fields are sized for the largest legal configuration (8 requesters, burst 8).
  localparam int TAG_ID_W = 3;
  localparam int TAG_BC_W = 4;

  typedef enum logic {
    IDLE,
    WR_BURST
  } arb_state_t;

  typedef struct packed {
    logic [TAG_ID_W-1:0] id;
    logic [TAG_BC_W-1:0] burstcount;
  } tag_t;

endpackage

// File: rtl/rsp_tag_fifo.sv
// Synchronous tag FIFO recording the requester and length of each read in flight.
module rsp_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          r_full;
  logic          r_empty;
  logic          w_do_push;
  logic          w_do_pop;
  logic [AW:0]   w_cnt_nxt;

  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_do_push && !w_do_pop) w_cnt_nxt = r_cnt + 1'b1;
    if (!w_do_push && w_do_pop) w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the mem_0 Avalon-MM master among NUM_REQ load/store units,
// with burst-locked writes and in-order read-response routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int BURST_W         = DEF_BURST_W,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_byteenable,
  input  logic [NUM_REQ*BURST_W-1:0]  req_burstcount,
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_readdatavalid,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_writedata,
  output logic [DATA_W/8-1:0]         mem_byteenable,
  output logic [BURST_W-1:0]          mem_burstcount,
  input  logic                        mem_waitrequest,
  input  logic [DATA_W-1:0]           mem_readdata,
  input  logic                        mem_readdatavalid,
  output logic                        busy,
  output logic                        err_unexpected_rdv
);

  localparam int          IDW = $clog2(NUM_REQ);
  localparam int unsigned NR  = NUM_REQ;

  arb_state_t         r_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_owner;
  logic [BURST_W-1:0] r_remaining;
  logic [TAG_BC_W-1:0] r_beat_cnt;
  logic               r_err;

  logic [NUM_REQ-1:0] w_want;
  logic               w_found;
  logic [IDW-1:0]     w_scan;
  logic [IDW-1:0]     w_gid;
  logic               w_valid;
  logic               w_is_write;
  logic               w_is_read;
  logic               w_stall;
  logic               w_accept;
  logic [BURST_W-1:0] w_bc;
  logic [BURST_W-1:0] w_bc_eff;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_rdv_ok;
  logic               w_last;
  tag_t               w_tag_in;
  tag_t               w_head;

  function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] id);
    return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  assign w_want = req_read | req_write;

  always_comb begin
    w_found = 1'b0;
    w_scan  = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!w_found && w_want[(32'(r_ptr) + k) % NR]) begin
        w_found = 1'b1;
        w_scan  = IDW'((32'(r_ptr) + k) % NR);
      end
    end
  end

  // The burst owner keeps the grant; mem_read is never issued mid-burst.
  assign w_gid      = (r_state == WR_BURST) ? r_owner : w_scan;
  assign w_valid    = rstn & ((r_state == WR_BURST) | w_found);
  assign w_is_write = req_write[w_gid];
  assign w_is_read  = (r_state == IDLE) & req_read[w_gid] & ~req_write[w_gid];
  assign w_stall    = (w_is_read & w_full) | ((r_state == WR_BURST) & ~req_write[r_owner]);

  assign mem_read       = w_valid & w_is_read & ~w_full;
  assign mem_write      = w_valid & w_is_write;
  assign mem_address    = req_address[w_gid*ADDR_W +: ADDR_W];
  assign mem_writedata  = req_writedata[w_gid*DATA_W +: DATA_W];
  assign mem_byteenable = req_byteenable[w_gid*(DATA_W/8) +: DATA_W/8];
  assign w_bc           = req_burstcount[w_gid*BURST_W +: BURST_W];
  assign mem_burstcount = w_bc;
  assign w_bc_eff       = (w_bc == '0) ? BURST_W'(1) : w_bc;

  assign w_gnt_oh        = w_valid ? (NUM_REQ'(1) << w_gid) : '0;
  assign req_waitrequest = ~(w_gnt_oh & {NUM_REQ{~mem_waitrequest & ~w_stall}});
  assign w_accept        = (mem_read | mem_write) & ~mem_waitrequest;

  assign w_push   = mem_read & ~mem_waitrequest;
  assign w_tag_in = '{id: TAG_ID_W'(w_gid), burstcount: TAG_BC_W'(w_bc_eff)};

  rsp_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     ($bits(tag_t))
  ) u_tag_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (w_tag_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_rdv_ok          = mem_readdatavalid & ~w_empty;
  assign w_last            = ((r_beat_cnt + 1'b1) == w_head.burstcount);
  assign w_pop             = w_rdv_ok & w_last;
  assign req_readdata      = mem_readdata;
  assign req_readdatavalid = w_rdv_ok ? (NUM_REQ'(1) << w_head.id) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_remaining <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (mem_readdatavalid && w_empty) r_err <= 1'b1;
      if (w_pop)         r_beat_cnt <= '0;
      else if (w_rdv_ok) r_beat_cnt <= r_beat_cnt + 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (mem_write && (w_bc_eff > BURST_W'(1))) begin
              r_state     <= WR_BURST;
              r_remaining <= w_bc_eff - 1'b1;
              r_owner     <= w_gid;
            end else begin
              r_ptr <= f_next(w_gid);
            end
          end
        end
        WR_BURST: begin
          if (w_accept) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == BURST_W'(1)) begin
              r_state <= IDLE;
              r_ptr   <= f_next(r_owner);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy               = (r_state != IDLE) | ~w_empty;
  assign err_unexpected_rdv = r_err;

  a_burst_nonzero: assert property (@(posedge clk) disable iff (!rstn)
    ((mem_read | mem_write) && (r_state == IDLE)) |-> (w_bc != '0));

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the kernel's single 512-bit Avalon-MM global-memory master (mem_0) among NUM_REQ kernel load/store units.
- Round-robin command arbitration, burst-locked writes, in-order routing of read responses back to the issuing requester.
- Sits between the kernel datapath and the mem_0 port of the kernel top; exports busy for completion gating.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 33, byte address width
DATA_W, 512, data width
BURST_W, 4, burstcount width (bursts 1..8)
MAX_OUTSTANDING, 16, read commands in flight; power of 2

Ports:
clk  in  1  kernel clock
rstn  in  1  reset, asynchronous, active-low
req_address  in  NUM_REQ*ADDR_W  per-requester address, packed, requester 0 at LSBs
req_read  in  NUM_REQ  read command
req_write  in  NUM_REQ  write beat
req_writedata  in  NUM_REQ*DATA_W  write data
req_byteenable  in  NUM_REQ*DATA_W/8  byte enables
req_burstcount  in  NUM_REQ*BURST_W  burst length
req_waitrequest  out  NUM_REQ  per-requester stall
req_readdata  out  DATA_W  broadcast read data
req_readdatavalid  out  NUM_REQ  one-hot read-data strobe
mem_address  out  ADDR_W  to mem_0_address
mem_read  out  1  to mem_0_read
mem_write  out  1  to mem_0_write
mem_writedata  out  DATA_W  to mem_0_writedata
mem_byteenable  out  DATA_W/8  to mem_0_byteenable
mem_burstcount  out  BURST_W  to mem_0_burstcount
mem_waitrequest  in  1  from mem_0_waitrequest
mem_readdata  in  DATA_W  from mem_0_readdata
mem_readdatavalid  in  1  from mem_0_readdatavalid
busy  out  1  write burst open or reads outstanding
err_unexpected_rdv  out  1  sticky: readdatavalid with no outstanding read

Behaviour:
- While rstn low: state IDLE, rr pointer 0, tag FIFO empty, beat counter 0, err 0. mem_read/mem_write 0, req_waitrequest all 1, req_readdatavalid 0, busy 0.
- States: IDLE, WR_BURST.
- IDLE: grant = first requester with req_read|req_write, scanning from pointer upward with wrap. No requester -> mem_read/mem_write 0.
- Command path is combinational, zero added latency: granted requester's fields are muxed onto mem_*.
- Accept: granted command with mem_waitrequest low. req_waitrequest[i] = ~(grant[i] & ~mem_waitrequest & ~stall). All non-granted requesters see 1.
- Both req_read and req_write high on one requester: write wins.
- Read stall: tag FIFO full (occupancy before any same-cycle pop) -> mem_read forced 0, granted requester held.
- Read accept: push {id, burstcount} into tag FIFO; pointer <= id+1 mod NUM_REQ.
- Write accept, burstcount 1: stay IDLE; pointer advances.
- Write accept, burstcount B>1: go to WR_BURST with remaining = B-1; grant locked to the owner.
- WR_BURST: only the owner is forwarded; address/burstcount pass through but are don't-care. Each accepted beat decrements remaining. At 0 -> IDLE and pointer advances. Reads from the owner and other requests are stalled.
- Response: req_readdata = mem_readdata combinationally. On mem_readdatavalid, req_readdatavalid[head.id] = 1 in the same cycle; head beat counter increments. On the last beat (counter+1 == head.burstcount), pop and clear the counter.
- Same-cycle push and pop are both performed.
- mem_readdatavalid with FIFO empty: data dropped, err_unexpected_rdv set until reset.
- burstcount 0 is illegal from requesters (simulation assertion); treated as 1.
- busy = (state != IDLE) | FIFO non-empty.
- Reset mid-burst or with reads outstanding: all state is discarded. The system must quiesce mem_0 before asserting rstn.

Decomposition:
- Package mem_arb_pkg: ADDR_W/DATA_W/BURST_W defaults, state enum {IDLE, WR_BURST}, tag struct {id, burstcount}.
- Sub-module rsp_tag_fifo: synchronous FIFO, depth MAX_OUTSTANDING, registered full/empty, same-cycle push/pop.

Test Plan:
- All 4 requesters assert single-beat reads, waitrequest 0 -> grants 0,1,2,3 on consecutive cycles; read data returned in order strobes req_readdatavalid 0001,0010,0100,1000.
- Requester 1 writes burst 4 while requester 2 requests -> 4 consecutive mem_write beats from requester 1; requester 2 granted on the 5th cycle.
- Requester 0 issues a burst-8 read, then requester 3 issues a burst-2 read -> 8 beats to requester 0, then 2 to requester 3; busy falls after the 10th beat.
- mem_waitrequest held 1 for 3 cycles during a read -> mem_* stable; requester waitrequest 1; accepted on cycle 4, one tag pushed.
- Issue 16 reads with no responses -> 17th stalled with mem_read 0. One readdatavalid ending a burst-1 -> stall released the next cycle.
- readdatavalid pulse with FIFO empty -> err_unexpected_rdv=1, no req_readdatavalid. rstn pulse -> err cleared.
